// File: rtl/comfort_thermostat_if.sv
// Reading/command bundle between a DHT11 reader (master) and the comfort
// thermostat (slave): reading strobe and values in, averages and drives out.
interface comfort_thermostat_if;
  logic       done;
  logic [7:0] temp;
  logic [7:0] hum;
  logic [7:0] temp_avg;
  logic [7:0] hum_avg;
  logic       avg_valid;
  logic       heater_on;
  logic       fan_on;
  logic       sensor_fault;

  modport master (
    output done, temp, hum,
    input  temp_avg, hum_avg, avg_valid, heater_on, fan_on, sensor_fault
  );

  modport slave (
    input  done, temp, hum,
    output temp_avg, hum_avg, avg_valid, heater_on, fan_on, sensor_fault
  );
endinterface

// File: rtl/comfort_thermostat.sv
// Comfort thermostat: range-checks DHT11 readings, keeps a 4-sample moving
// average and drives heater/fan through a dwell-limited hysteresis FSM.
module comfort_thermostat #(
  parameter logic [7:0]  SETPOINT    = 8'd25,
  parameter logic [7:0]  HYST        = 8'd1,
  parameter logic [7:0]  TEMP_MAX    = 8'd50,
  parameter logic [7:0]  HUM_MAX     = 8'd90,
  parameter int unsigned DWELL_CYC   = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  comfort_thermostat_if.slave  bus
);
  localparam int DW = $clog2(DWELL_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);
  localparam logic [8:0]    SP_TH = {1'b0, SETPOINT};
  localparam logic [8:0]    LO_TH = SP_TH - {1'b0, HYST};
  localparam logic [8:0]    HI_TH = SP_TH + {1'b0, HYST};

  typedef enum logic [1:0] {IDLE, NEUTRAL, HEATING, COOLING} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   dwell_reg;
  logic [TW-1:0]   timeout_reg;
  logic            done_d_reg;
  logic [7:0]      temp_buf_reg [4];
  logic [7:0]      hum_buf_reg  [4];
  logic [2:0]      count_reg;
  logic [7:0]      temp_avg_reg, hum_avg_reg;
  logic            avg_valid_reg, fault_reg;

  logic            done_rise, accept, fault_trip, elapsed;
  logic [9:0]      temp_ext [4];
  logic [9:0]      hum_ext  [4];
  logic [9:0]      temp_sum, hum_sum;
  logic [8:0]      avg9;

  assign done_rise  = bus.done & ~done_d_reg;
  assign accept     = (bus.temp <= TEMP_MAX) && (bus.hum <= HUM_MAX);
  // A reading edge in the same cycle as the timeout wins: the sensor is alive.
  assign fault_trip = (timeout_reg == TIMEOUT_LIM) && !done_rise;
  assign elapsed    = (dwell_reg >= DWELL_LAST);
  assign avg9       = {1'b0, temp_avg_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ext
      assign temp_ext[gi] = {2'b00, temp_buf_reg[gi]};
      assign hum_ext[gi]  = {2'b00, hum_buf_reg[gi]};
    end
  endgenerate

  assign temp_sum = temp_ext[0] + temp_ext[1] + temp_ext[2] + temp_ext[3];
  assign hum_sum  = hum_ext[0] + hum_ext[1] + hum_ext[2] + hum_ext[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      done_d_reg    <= 1'b0;
      timeout_reg   <= '0;
      count_reg     <= '0;
      fault_reg     <= 1'b0;
      temp_avg_reg  <= '0;
      hum_avg_reg   <= '0;
      avg_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        temp_buf_reg[i] <= '0;
        hum_buf_reg[i]  <= '0;
      end
    end else begin
      done_d_reg <= bus.done;

      if (done_rise)
        timeout_reg <= '0;
      else if (timeout_reg != TIMEOUT_LIM)
        timeout_reg <= timeout_reg + TW'(1);

      if (fault_trip) begin
        fault_reg <= 1'b1;
        count_reg <= '0;
        for (int i = 0; i < 4; i++) begin
          temp_buf_reg[i] <= '0;
          hum_buf_reg[i]  <= '0;
        end
      end else if (done_rise) begin
        fault_reg <= 1'b0;
        if (accept) begin
          temp_buf_reg[0] <= bus.temp;
          hum_buf_reg[0]  <= bus.hum;
          for (int i = 1; i < 4; i++) begin
            temp_buf_reg[i] <= temp_buf_reg[i-1];
            hum_buf_reg[i]  <= hum_buf_reg[i-1];
          end
          if (count_reg != 3'd4)
            count_reg <= count_reg + 3'd1;
        end
      end

      // Averages lag the buffers by one cycle and read zero until the window is full.
      if (fault_trip || count_reg != 3'd4) begin
        temp_avg_reg  <= '0;
        hum_avg_reg   <= '0;
        avg_valid_reg <= 1'b0;
      end else begin
        temp_avg_reg  <= temp_sum[9:2];
        hum_avg_reg   <= hum_sum[9:2];
        avg_valid_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      dwell_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        dwell_reg <= '0;
      else if (!elapsed)
        dwell_reg <= dwell_reg + DW'(1);
    end
  end

  // Crossings seen before the dwell expires stay pending because the
  // condition is re-evaluated every cycle against the held average.
  always_comb begin
    state_next = state_reg;
    if (fault_trip || !avg_valid_reg) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (avg9 < LO_TH)      state_next = HEATING;
          else if (avg9 > HI_TH) state_next = COOLING;
          else                   state_next = NEUTRAL;
        end
        NEUTRAL: begin
          if (elapsed && avg9 < LO_TH)      state_next = HEATING;
          else if (elapsed && avg9 > HI_TH) state_next = COOLING;
        end
        HEATING: if (elapsed && avg9 >= SP_TH) state_next = NEUTRAL;
        COOLING: if (elapsed && avg9 <= SP_TH) state_next = NEUTRAL;
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.temp_avg     = temp_avg_reg;
  assign bus.hum_avg      = hum_avg_reg;
  assign bus.avg_valid    = avg_valid_reg;
  assign bus.heater_on    = (state_reg == HEATING);
  assign bus.fan_on       = (state_reg == COOLING);
  assign bus.sensor_fault = fault_reg;
endmodule

// File: tb/tb_comfort_thermostat.sv
// Bench for comfort_thermostat: directed scenarios plus randomized readings
// checked against a queue-based behavioural model of the thermostat.
module tb_comfort_thermostat;
  localparam int SP = 25, LO = 24, HI = 26, TMAX = 50, HMAX = 90;
  localparam int DWELL = 20, TOUT = 1000;

  typedef enum int {M_IDLE, M_NEUT, M_HEAT, M_COOL} mode_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  comfort_thermostat_if bus ();

  comfort_thermostat #(
    .DWELL_CYC  (DWELL),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: accepted readings kept as a sliding queue.
  int    q_t[$];
  int    q_h[$];
  bit    m_prev, m_fault, m_valid;
  int    m_quiet, m_tavg, m_havg, m_age;
  mode_t m_mode;

  task automatic model_step(input bit d, input int t, input int h, input bit r);
    bit rise, trip, ok;
    mode_t nm;
    int st, sh;
    if (r) begin
      q_t.delete(); q_h.delete();
      m_prev = 0; m_fault = 0; m_valid = 0;
      m_quiet = 0; m_tavg = 0; m_havg = 0; m_age = 0;
      m_mode = M_IDLE;
      return;
    end
    rise = d && !m_prev;
    trip = !rise && (m_quiet >= TOUT);
    ok   = (m_age >= DWELL - 1);
    nm   = m_mode;
    if (trip || !m_valid) nm = M_IDLE;
    else begin
      case (m_mode)
        M_IDLE: nm = (m_tavg < LO) ? M_HEAT : (m_tavg > HI) ? M_COOL : M_NEUT;
        M_NEUT: if (ok && m_tavg < LO) nm = M_HEAT; else if (ok && m_tavg > HI) nm = M_COOL;
        M_HEAT: if (ok && m_tavg >= SP) nm = M_NEUT;
        M_COOL: if (ok && m_tavg <= SP) nm = M_NEUT;
        default: nm = M_IDLE;
      endcase
    end
    m_age  = (nm != m_mode) ? 0 : m_age + 1;
    m_mode = nm;
    st = 0; sh = 0;
    foreach (q_t[i]) st += q_t[i];
    foreach (q_h[i]) sh += q_h[i];
    if (!trip && q_t.size() == 4) begin
      m_valid = 1; m_tavg = st / 4; m_havg = sh / 4;
    end else begin
      m_valid = 0; m_tavg = 0; m_havg = 0;
    end
    if (trip) begin
      q_t.delete(); q_h.delete(); m_fault = 1;
    end else if (rise) begin
      m_fault = 0;
      if (t <= TMAX && h <= HMAX) begin
        q_t.push_back(t); q_h.push_back(h);
        if (q_t.size() > 4) begin
          void'(q_t.pop_front()); void'(q_h.pop_front());
        end
      end
    end
    m_quiet = rise ? 0 : ((m_quiet < TOUT) ? m_quiet + 1 : TOUT);
    m_prev  = d;
  endtask

  task automatic tick();
    model_step(bus.done, int'(bus.temp), int'(bus.hum), rst);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int t, input int h, input int width, input int gap);
    $display("txn send temp=%0d hum=%0d width=%0d gap=%0d", t, h, width, gap);
    bus.temp = 8'(t);
    bus.hum  = 8'(h);
    bus.done = 1'b1;
    repeat (width) tick();
    bus.done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.done = 1'b0; bus.temp = 8'd0; bus.hum = 8'd0;
    repeat (5) tick();
    checks++; if (bus.temp_avg !== 8'd0) begin errors++; $display("FAIL reset_temp_avg got %0d exp 0", bus.temp_avg); end
    checks++; if (bus.hum_avg !== 8'd0) begin errors++; $display("FAIL reset_hum_avg got %0d exp 0", bus.hum_avg); end
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid got %b exp 0", bus.avg_valid); end
    checks++; if (bus.heater_on !== 1'b0) begin errors++; $display("FAIL reset_heater got %b exp 0", bus.heater_on); end
    checks++; if (bus.fan_on !== 1'b0) begin errors++; $display("FAIL reset_fan got %b exp 0", bus.fan_on); end
    checks++; if (bus.sensor_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", bus.sensor_fault); end
    rst = 1'b0;
  endtask

  task automatic test_heat_start();
    for (int i = 0; i < 3; i++) begin
      send(22, 40, 1, 3);
      checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL start_early_valid sample %0d got %b exp 0", i, bus.avg_valid); end
    end
    send(22, 40, 1, 0);
    tick();
    checks++; if (bus.avg_valid !== 1'b1) begin errors++; $display("FAIL start_valid got %b exp 1", bus.avg_valid); end
    checks++; if (bus.temp_avg !== 8'd22) begin errors++; $display("FAIL start_temp_avg got %0d exp 22", bus.temp_avg); end
    checks++; if (bus.hum_avg !== 8'd40) begin errors++; $display("FAIL start_hum_avg got %0d exp 40", bus.hum_avg); end
    checks++; if (bus.heater_on !== 1'b0) begin errors++; $display("FAIL start_heater_early got %b exp 0", bus.heater_on); end
    tick();
    checks++; if (bus.heater_on !== 1'b1) begin errors++; $display("FAIL start_heater got %b exp 1", bus.heater_on); end
    checks++; if (bus.fan_on !== 1'b0) begin errors++; $display("FAIL start_fan got %b exp 0", bus.fan_on); end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.heater_on !== 1'b0) begin errors++; $display("FAIL start_rst_heater got %b exp 0", bus.heater_on); end
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL start_rst_valid got %b exp 0", bus.avg_valid); end
    rst = 1'b0;
  endtask

  task automatic test_hysteresis();
    int exp_up[4]   = '{23, 24, 25, 26};
    int exp_cool[4] = '{26, 26, 26, 27};
    do_reset();
    repeat (4) send(22, 40, 1, 3);
    repeat (40) tick();
    checks++; if (bus.heater_on !== 1'b1) begin errors++; $display("FAIL hyst_heat got %b exp 1", bus.heater_on); end
    for (int i = 0; i < 4; i++) begin
      send(26, 40, 1, 0);
      tick();
      checks++; if (bus.temp_avg !== 8'(exp_up[i])) begin errors++; $display("FAIL hyst_up_avg step %0d got %0d exp %0d", i, bus.temp_avg, exp_up[i]); end
      repeat (28) tick();
      checks++; if (bus.heater_on !== (i < 2)) begin errors++; $display("FAIL hyst_up_heater step %0d got %b exp %b", i, bus.heater_on, (i < 2)); end
      checks++; if (bus.fan_on !== 1'b0) begin errors++; $display("FAIL hyst_up_fan step %0d got %b exp 0", i, bus.fan_on); end
    end
    for (int i = 0; i < 4; i++) begin
      send(27, 40, 1, 0);
      tick();
      checks++; if (bus.temp_avg !== 8'(exp_cool[i])) begin errors++; $display("FAIL hyst_cool_avg step %0d got %0d exp %0d", i, bus.temp_avg, exp_cool[i]); end
      repeat (28) tick();
      checks++; if (bus.fan_on !== (i == 3)) begin errors++; $display("FAIL hyst_cool_fan step %0d got %b exp %b", i, bus.fan_on, (i == 3)); end
      checks++; if (bus.heater_on !== 1'b0) begin errors++; $display("FAIL hyst_cool_heater step %0d got %b exp 0", i, bus.heater_on); end
    end
  endtask

  task automatic test_dwell();
    int dropped = -1;
    do_reset();
    repeat (4) send(20, 40, 1, 1);
    $display("txn send temp=30 hum=40 width=1 gap=0");
    bus.temp = 8'd30; bus.done = 1'b1;
    tick();
    checks++; if (bus.heater_on !== 1'b1) begin errors++; $display("FAIL dwell_entry got %b exp 1", bus.heater_on); end
    for (int c = 1; c <= 40; c++) begin
      bus.done = (c == 2);
      tick();
      if (c == 5) begin
        checks++; if (bus.temp_avg !== 8'd25) begin errors++; $display("FAIL dwell_avg got %0d exp 25", bus.temp_avg); end
      end
      checks++; if (bus.heater_on !== (m_mode == M_HEAT)) begin errors++; $display("FAIL dwell_track cyc %0d got %b exp %b", c, bus.heater_on, (m_mode == M_HEAT)); end
      if (dropped < 0 && bus.heater_on === 1'b0) dropped = c;
    end
    checks++; if (dropped != 20) begin errors++; $display("FAIL dwell_release got cycle %0d exp 20", dropped); end
    do_reset();
    send(25, 40, 1, 1); send(25, 40, 1, 1); send(25, 40, 1, 1);
    send(26, 40, 1, 0);
    tick();
    checks++; if (bus.temp_avg !== 8'd25) begin errors++; $display("FAIL trunc_avg got %0d exp 25", bus.temp_avg); end
  endtask

  task automatic test_range();
    do_reset();
    repeat (4) send(24, 40, 1, 1);
    repeat (50) tick();
    checks++; if (bus.temp_avg !== 8'd24) begin errors++; $display("FAIL range_base got %0d exp 24", bus.temp_avg); end
    send(60, 40, 1, 1);
    checks++; if (bus.temp_avg !== 8'd24) begin errors++; $display("FAIL range_temp_rej got %0d exp 24", bus.temp_avg); end
    checks++; if (bus.avg_valid !== 1'b1) begin errors++; $display("FAIL range_valid got %b exp 1", bus.avg_valid); end
    repeat (990) tick();
    checks++; if (bus.sensor_fault !== 1'b0) begin errors++; $display("FAIL range_timeout_clear got %b exp 0", bus.sensor_fault); end
    send(28, 95, 1, 1);
    checks++; if (bus.temp_avg !== 8'd24) begin errors++; $display("FAIL range_hum_rej got %0d exp 24", bus.temp_avg); end
    send(28, 40, 1, 1);
    checks++; if (bus.temp_avg !== 8'd25) begin errors++; $display("FAIL range_after got %0d exp 25", bus.temp_avg); end
    checks++; if (bus.hum_avg !== 8'd40) begin errors++; $display("FAIL range_hum_avg got %0d exp 40", bus.hum_avg); end
  endtask

  task automatic test_timeout();
    int n = -1;
    int n_model = -1;
    do_reset();
    repeat (4) send(20, 40, 1, 1);
    repeat (5) tick();
    checks++; if (bus.heater_on !== 1'b1) begin errors++; $display("FAIL tout_heat got %b exp 1", bus.heater_on); end
    for (int k = 1; k <= 1100 && n < 0; k++) begin
      tick();
      if (n_model < 0 && m_fault) n_model = k;
      if (bus.sensor_fault === 1'b1) n = k;
    end
    checks++; if (n != 995 || n != n_model) begin errors++; $display("FAIL tout_cycle got %0d exp 995 (model %0d)", n, n_model); end
    checks++; if (bus.heater_on !== 1'b0) begin errors++; $display("FAIL tout_heater got %b exp 0", bus.heater_on); end
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL tout_valid got %b exp 0", bus.avg_valid); end
    checks++; if (bus.temp_avg !== 8'd0) begin errors++; $display("FAIL tout_avg got %0d exp 0", bus.temp_avg); end
    tick();
    checks++; if (bus.sensor_fault !== 1'b1) begin errors++; $display("FAIL tout_sticky got %b exp 1", bus.sensor_fault); end
    for (int i = 0; i < 3; i++) begin
      send(20, 40, 1, 1);
      checks++; if (bus.sensor_fault !== 1'b0) begin errors++; $display("FAIL tout_clear %0d got %b exp 0", i, bus.sensor_fault); end
      checks++; if (bus.heater_on !== 1'b0 || bus.avg_valid !== 1'b0) begin errors++; $display("FAIL tout_refill %0d got heater %b valid %b exp 0 0", i, bus.heater_on, bus.avg_valid); end
    end
    send(20, 40, 1, 2);
    checks++; if (bus.heater_on !== 1'b1 || bus.avg_valid !== 1'b1) begin errors++; $display("FAIL tout_recover got heater %b valid %b exp 1 1", bus.heater_on, bus.avg_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      int t, h, w, g;
      t = $urandom_range(32, 18);
      h = $urandom_range(80, 20);
      if ($urandom_range(7, 0) == 0) t = $urandom_range(255, 51);
      if ($urandom_range(7, 0) == 0) h = $urandom_range(255, 91);
      w = $urandom_range(3, 1);
      g = (i == 30) ? 1100 : $urandom_range(50, 1);
      $display("txn rand %0d temp=%0d hum=%0d width=%0d gap=%0d", i, t, h, w, g);
      bus.temp = 8'(t);
      bus.hum  = 8'(h);
      for (int c = 0; c < w + g; c++) begin
        bus.done = (c < w);
        tick();
        checks++; if (bus.temp_avg !== 8'(m_tavg)) begin errors++; $display("FAIL rand_temp_avg txn %0d cyc %0d got %0d exp %0d", i, c, bus.temp_avg, m_tavg); end
        checks++; if (bus.hum_avg !== 8'(m_havg)) begin errors++; $display("FAIL rand_hum_avg txn %0d cyc %0d got %0d exp %0d", i, c, bus.hum_avg, m_havg); end
        checks++; if (bus.avg_valid !== m_valid) begin errors++; $display("FAIL rand_valid txn %0d cyc %0d got %b exp %b", i, c, bus.avg_valid, m_valid); end
        checks++; if (bus.heater_on !== (m_mode == M_HEAT)) begin errors++; $display("FAIL rand_heater txn %0d cyc %0d got %b exp %b", i, c, bus.heater_on, (m_mode == M_HEAT)); end
        checks++; if (bus.fan_on !== (m_mode == M_COOL)) begin errors++; $display("FAIL rand_fan txn %0d cyc %0d got %b exp %b", i, c, bus.fan_on, (m_mode == M_COOL)); end
        checks++; if (bus.sensor_fault !== m_fault) begin errors++; $display("FAIL rand_fault txn %0d cyc %0d got %b exp %b", i, c, bus.sensor_fault, m_fault); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.done = 1'b0;
    bus.temp = 8'd0;
    bus.hum  = 8'd0;
    test_reset();
    test_heat_start();
    test_hysteresis();
    test_dwell();
    test_range();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
